// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, bus mode and receiver state encoding.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 8;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic msb_first;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0, msb_first: 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall strobes on the synced level.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 target receiver: synchronises SCLK/MOSI/SS, shifts MSB-first words, valid/ack holding register.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ss_s, ss_rise, ss_fall;
    logic unused_sync;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(MOSI), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    // SS resets low so a select held across reset release never looks like a new frame.
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
        .clk(clk), .reset(reset), .d(SS), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );

    assign unused_sync = &{1'b0, sclk_s, sclk_fall, mosi_rise, mosi_fall, ss_s};

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_err_q, frame_err_d;
    logic                    word_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            RECV: begin
                // Deselect takes priority over a coincident SCLK edge.
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (word_done) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_d;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == RECV);

endmodule
